// File: rtl/share_port_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : share_port_bridge                                               |
// | Brief    : Regroups share-major words bit-major for a masked S-box core,   |
// |            gathers fresh PRD beats and returns core results share-major.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module share_port_bridge #(
    parameter int WIDTH     = 8,
    parameter int NSHARES   = 2,
    parameter int RND_W     = 28,
    parameter int PRD_CHUNK = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH*NSHARES-1:0]   data_i,
    input  logic [1:0]                 op_i,
    input  logic                       prd_valid_i,
    input  logic [PRD_CHUNK-1:0]       prd_i,
    output logic                       prd_ready_o,
    output logic                       en_o,
    output logic [1:0]                 op_o,
    output logic [WIDTH*NSHARES-1:0]   bits_o,
    output logic [RND_W-1:0]           prd_o,
    input  logic                       out_req_i,
    input  logic [WIDTH*NSHARES-1:0]   core_bits_i,
    output logic                       out_ack_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH*NSHARES-1:0]   data_o
);

    localparam int c_DW     = WIDTH * NSHARES;
    localparam int c_NBEATS = RND_W / PRD_CHUNK;
    localparam int c_CNT_W  = $clog2(c_NBEATS + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(c_NBEATS);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ARM  = 3'd1;
    localparam logic [2:0] c_ST_FIRE = 3'd2;
    localparam logic [2:0] c_ST_WAIT = 3'd3;
    localparam logic [2:0] c_ST_HOLD = 3'd4;

    generate
        if ((RND_W % PRD_CHUNK) != 0 || NSHARES < 2) begin : g_param_check
            $error("share_port_bridge: RND_W must be a multiple of PRD_CHUNK and NSHARES >= 2");
        end
    endgenerate

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_DW-1:0]    r_bits;
    logic [c_DW-1:0]    r_data;
    logic [1:0]         r_op;
    logic [RND_W-1:0]   r_prd;
    logic [RND_W-1:0]   r_col;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ack;
    logic [c_DW-1:0]    w_bits_in;
    logic [c_DW-1:0]    w_data_in;
    logic               w_full;
    logic               w_accept;
    logic               w_fire;
    logic               w_beat;
    logic               w_req;
    logic               w_done;

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            for (genvar s = 0; s < NSHARES; s++) begin : g_share
                assign w_bits_in[b*NSHARES+s] = data_i[s*WIDTH+b];
                assign w_data_in[s*WIDTH+b]   = core_bits_i[b*NSHARES+s];
            end
        end
    endgenerate

    assign w_full   = (r_cnt == c_FULL);
    assign w_accept = (r_state == c_ST_IDLE) && in_valid_i;
    assign w_fire   = (r_state == c_ST_ARM) && w_full;
    // A full collector refuses beats, so a fill can never coincide with the snapshot.
    assign w_beat   = prd_valid_i && !w_full;
    assign w_req    = (r_state == c_ST_WAIT) && out_req_i;
    assign w_done   = (r_state == c_ST_HOLD) && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid_i)  w_state_next = c_ST_ARM;
            c_ST_ARM:  if (w_full)      w_state_next = c_ST_FIRE;
            c_ST_FIRE:                  w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (out_req_i)   w_state_next = c_ST_HOLD;
            c_ST_HOLD: if (out_ready_i) w_state_next = c_ST_IDLE;
            default:                    w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_bits <= '0;
            r_data <= '0;
            r_op   <= '0;
            r_prd  <= '0;
            r_col  <= '0;
            r_cnt  <= '0;
            r_ack  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bits <= w_bits_in;
                r_op   <= op_i;
            end
            if (w_fire) begin
                r_prd <= r_col;
                r_col <= '0;
                r_cnt <= '0;
            end else if (w_beat) begin
                r_col[32'(r_cnt)*PRD_CHUNK +: PRD_CHUNK] <= prd_i;
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            r_ack <= w_req;
            if (w_req) begin
                r_data <= w_data_in;
            end
            // Scrub shares and randomness once the result has been handed off.
            if (w_done) begin
                r_data <= '0;
                r_bits <= '0;
                r_prd  <= '0;
            end
        end
    end

    assign in_ready_o  = (r_state == c_ST_IDLE);
    assign prd_ready_o = !w_full;
    assign en_o        = (r_state == c_ST_FIRE);
    assign op_o        = r_op;
    assign bits_o      = r_bits;
    assign prd_o       = r_prd;
    assign out_ack_o   = r_ack;
    assign out_valid_o = (r_state == c_ST_HOLD);
    assign data_o      = r_data;

endmodule
`default_nettype wire

// File: tb/tb_share_port_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_share_port_bridge                                            |
// | Brief    : Directed vector bench for share_port_bridge.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_share_port_bridge;

    localparam int WIDTH     = 8;
    localparam int NSHARES   = 2;
    localparam int RND_W     = 28;
    localparam int PRD_CHUNK = 4;
    localparam int DW        = WIDTH * NSHARES;

    logic              clk_i;
    logic              rst_ni;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DW-1:0]     data_i;
    logic [1:0]        op_i;
    logic              prd_valid_i;
    logic [PRD_CHUNK-1:0] prd_i;
    logic              prd_ready_o;
    logic              en_o;
    logic [1:0]        op_o;
    logic [DW-1:0]     bits_o;
    logic [RND_W-1:0]  prd_o;
    logic              out_req_i;
    logic [DW-1:0]     core_bits_i;
    logic              out_ack_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DW-1:0]     data_o;

    share_port_bridge #(
        .WIDTH(WIDTH), .NSHARES(NSHARES), .RND_W(RND_W), .PRD_CHUNK(PRD_CHUNK)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_i(data_i), .op_i(op_i),
        .prd_valid_i(prd_valid_i), .prd_i(prd_i), .prd_ready_o(prd_ready_o),
        .en_o(en_o), .op_o(op_o), .bits_o(bits_o), .prd_o(prd_o),
        .out_req_i(out_req_i), .core_bits_i(core_bits_i), .out_ack_o(out_ack_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data_o(data_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  op;
        logic [15:0] exp_bits;
        logic [15:0] core;
        logic [15:0] exp_data;
        logic [3:0]  seed;
        int          n_hold;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic push_beat(input logic [3:0] v);
        prd_valid_i = 1'b1;
        prd_i       = v;
        smp();
        check("prd_ready_beat", 32'(prd_ready_o), 32'd1);
        check("en_low_while_filling", 32'(en_o), 32'd0);
        cyc();
        prd_valid_i = 1'b0;
    endtask

    task automatic accept(input logic [15:0] d, input logic [1:0] op);
        in_valid_i = 1'b1;
        data_i     = d;
        op_i       = op;
        smp();
        check("in_ready_idle", 32'(in_ready_o), 32'd1);
        cyc();
        in_valid_i = 1'b0;
        data_i     = '0;
    endtask

    task automatic finish_op(input logic [15:0] core, input logic [15:0] exp_data,
                             input logic [15:0] exp_bits, input logic [27:0] exp_prd,
                             input int n_hold);
        smp();
        check("wait_en_low", 32'(en_o), 32'd0);
        check("wait_bits", 32'(bits_o), 32'(exp_bits));
        check("wait_prd", 32'(prd_o), 32'(exp_prd));
        check("wait_valid_low", 32'(out_valid_o), 32'd0);
        cyc();
        out_req_i   = 1'b1;
        core_bits_i = core;
        cyc();
        out_req_i   = 1'b0;
        core_bits_i = ~core;
        smp();
        check("ack_pulse", 32'(out_ack_o), 32'd1);
        check("valid_rise", 32'(out_valid_o), 32'd1);
        check("data_regroup", 32'(data_o), 32'(exp_data));
        for (int i = 0; i < n_hold; i++) begin
            cyc();
            smp();
            check("hold_ack_low", 32'(out_ack_o), 32'd0);
            check("hold_valid", 32'(out_valid_o), 32'd1);
            check("hold_data_stable", 32'(data_o), 32'(exp_data));
        end
        cyc();
        out_ready_i = 1'b1;
        cyc();
        out_ready_i = 1'b0;
        smp();
        check("done_valid_low", 32'(out_valid_o), 32'd0);
        check("done_data_clear", 32'(data_o), 32'd0);
        check("done_bits_clear", 32'(bits_o), 32'd0);
        check("done_prd_clear", 32'(prd_o), 32'd0);
        check("done_in_ready", 32'(in_ready_o), 32'd1);
        cyc();
    endtask

    logic [27:0] exp_prd;
    logic [27:0] snaps[2];
    int          n_snap;
    int          en_seen;
    int          ack_seen;
    int          same;
    logic [3:0]  beat_val;
    logic        consumed;

    initial begin
        vecs[0] = '{16'hA53C, 2'd1, 16'h8D72, 16'h8D72, 16'hA53C, 4'h1, 5};
        vecs[1] = '{16'hFF00, 2'd0, 16'hAAAA, 16'hAAAA, 16'hFF00, 4'h3, 1};
        vecs[2] = '{16'h00FF, 2'd2, 16'h5555, 16'h0002, 16'h0100, 4'h8, 1};
        vecs[3] = '{16'h0001, 2'd3, 16'h0001, 16'h4000, 16'h0080, 4'hC, 1};
        vecs[4] = '{16'h8000, 2'd1, 16'h8000, 16'h5555, 16'h00FF, 4'h5, 1};
        vecs[5] = '{16'h0080, 2'd2, 16'h4000, 16'hFFFF, 16'hFFFF, 4'hA, 1};

        rst_ni = 1'b0; in_valid_i = 1'b0; data_i = '0; op_i = '0;
        prd_valid_i = 1'b0; prd_i = '0; out_req_i = 1'b0; core_bits_i = '0;
        out_ready_i = 1'b0;
        cyc();
        cyc();
        rst_ni = 1'b1;
        smp();
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_prd_ready", 32'(prd_ready_o), 32'd1);
        check("rst_en", 32'(en_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_ack", 32'(out_ack_o), 32'd0);
        check("rst_bits", 32'(bits_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_prd", 32'(prd_o), 32'd0);
        check("rst_op", 32'(op_o), 32'd0);
        cyc();

        // Prefilled collector, regroup vectors, stalled HOLD on the first one.
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 7; k++) begin
                exp_prd[k*4 +: 4] = vecs[v].seed + 4'(k);
                push_beat(vecs[v].seed + 4'(k));
            end
            if (v == 0) check("t1_prd_const", 32'(exp_prd), 32'h7654321);
            smp();
            check("prd_ready_full", 32'(prd_ready_o), 32'd0);
            cyc();
            accept(vecs[v].data, vecs[v].op);
            smp();
            check("arm_en_low", 32'(en_o), 32'd0);
            check("arm_in_ready_low", 32'(in_ready_o), 32'd0);
            check("arm_bits", 32'(bits_o), 32'(vecs[v].exp_bits));
            check("arm_op", 32'(op_o), 32'(vecs[v].op));
            check("arm_prd_clear", 32'(prd_o), 32'd0);
            cyc();
            smp();
            check("fire_en", 32'(en_o), 32'd1);
            check("fire_prd", 32'(prd_o), 32'(exp_prd));
            check("fire_collector_cleared", 32'(prd_ready_o), 32'd1);
            cyc();
            finish_op(vecs[v].core, vecs[v].exp_data, vecs[v].exp_bits, exp_prd, vecs[v].n_hold);
        end

        // Slow PRD trickle with out_req_i held high outside WAIT.
        out_req_i   = 1'b1;
        core_bits_i = 16'hFFFF;
        smp();
        check("idle_req_no_ack", 32'(out_ack_o), 32'd0);
        cyc();
        accept(16'h1234, 2'd2);
        en_seen  = 0;
        ack_seen = 0;
        for (int k = 0; k < 7; k++) begin
            prd_valid_i = 1'b1;
            prd_i       = 4'(k + 9);
            smp();
            if (en_o) en_seen++;
            if (out_ack_o || out_valid_o) ack_seen++;
            cyc();
            prd_valid_i = 1'b0;
            if (k < 6) begin
                for (int g = 0; g < 2; g++) begin
                    smp();
                    if (en_o) en_seen++;
                    if (out_ack_o || out_valid_o) ack_seen++;
                    cyc();
                end
            end
        end
        out_req_i = 1'b0;
        smp();
        check("t2_en_early", 32'(en_seen), 32'd0);
        check("t3_req_ignored", 32'(ack_seen), 32'd0);
        check("t2_en_after_last_beat", 32'(en_o), 32'd0);
        cyc();
        smp();
        check("t2_fire", 32'(en_o), 32'd1);
        check("t2_prd", 32'(prd_o), 32'hFEDCBA9);
        cyc();
        finish_op(16'h0718, 16'h1234, 16'h0718, 28'hFEDCBA9, 1);

        // Reset in WAIT with beats buffered.
        for (int k = 0; k < 7; k++) push_beat(4'h3);
        accept(16'h00FF, 2'd3);
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) push_beat(4'h5);
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        smp();
        check("t5_in_ready", 32'(in_ready_o), 32'd1);
        check("t5_prd_ready", 32'(prd_ready_o), 32'd1);
        check("t5_en", 32'(en_o), 32'd0);
        check("t5_bits", 32'(bits_o), 32'd0);
        check("t5_prd", 32'(prd_o), 32'd0);
        check("t5_op", 32'(op_o), 32'd0);
        check("t5_valid", 32'(out_valid_o), 32'd0);
        check("t5_data", 32'(data_o), 32'd0);
        check("t5_ack", 32'(out_ack_o), 32'd0);
        cyc();
        accept(16'hA53C, 2'd1);
        for (int k = 0; k < 6; k++) push_beat(4'(k + 8));
        smp();
        check("t5_no_fire_6_beats", 32'(en_o), 32'd0);
        check("t5_need_beat", 32'(prd_ready_o), 32'd1);
        cyc();
        push_beat(4'hE);
        smp();
        check("t5_en_wait", 32'(en_o), 32'd0);
        cyc();
        smp();
        check("t5_fire", 32'(en_o), 32'd1);
        check("t5_prd_fresh", 32'(prd_o), 32'hEDCBA98);
        cyc();
        finish_op(16'h8D72, 16'hA53C, 16'h8D72, 28'hEDCBA98, 1);

        // Back-to-back ops with a continuous PRD stream.
        in_valid_i  = 1'b1;
        data_i      = 16'h5A5A;
        op_i        = 2'd0;
        out_req_i   = 1'b1;
        out_ready_i = 1'b1;
        core_bits_i = 16'h0F0F;
        prd_valid_i = 1'b1;
        beat_val    = 4'h1;
        n_snap      = 0;
        for (int c = 0; c < 200; c++) begin
            prd_i = beat_val;
            smp();
            consumed = prd_ready_o;
            if (en_o) begin
                snaps[n_snap] = prd_o;
                n_snap++;
            end
            if (n_snap == 2) break;
            cyc();
            if (consumed) beat_val = beat_val + 4'h1;
        end
        cyc();
        in_valid_i  = 1'b0;
        prd_valid_i = 1'b0;
        check("t6_two_fires", 32'(n_snap), 32'd2);
        check("t6_snap0", 32'(snaps[0]), 32'h7654321);
        check("t6_snap1", 32'(snaps[1]), 32'hEDCBA98);
        same = 0;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                if (snaps[0][i*4 +: 4] == snaps[1][j*4 +: 4]) same++;
        check("t6_no_shared_beat", 32'(same), 32'd0);
        for (int c = 0; c < 6; c++) cyc();
        out_req_i   = 1'b0;
        out_ready_i = 1'b0;
        smp();
        check("t6_back_idle", 32'(in_ready_o), 32'd1);
        check("t6_prd_clear", 32'(prd_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
